// File: rtl/apb_gpio_ng.sv
// apb_gpio_ng: APB GPIO controller for up to 32 pads. Per-pin direction,
// output, pad-mux function and interrupt configuration, atomic output
// set/clear, sticky W1C interrupt status and a prescaled glitch filter.
module apb_gpio_ng #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_GPIO       = 32,
  parameter int unsigned FILT_W         = 4
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NUM_GPIO-1:0]       gpio_in,
  output logic [NUM_GPIO-1:0]       gpio_out,
  output logic [NUM_GPIO-1:0]       gpio_dir,
  output logic [2*NUM_GPIO-1:0]     gpio_mux,
  output logic                      interrupt
);

  // Register offsets as decoded from PADDR[5:2]
  typedef enum logic [3:0] {
    OFF_PADDIR    = 4'h0,
    OFF_PADIN     = 4'h1,
    OFF_PADOUT    = 4'h2,
    OFF_PADOUTSET = 4'h3,
    OFF_PADOUTCLR = 4'h4,
    OFF_INTEN     = 4'h5,
    OFF_INTTYPE0  = 4'h6,
    OFF_INTTYPE1  = 4'h7,
    OFF_INTSTATUS = 4'h8,
    OFF_FILTEN    = 4'h9,
    OFF_FILTCFG   = 4'hA,
    OFF_PADFUN0   = 4'hB,
    OFF_PADFUN1   = 4'hC
  } reg_off_e;

  // Configuration registers
  logic [NUM_GPIO-1:0] r_dir;
  logic [NUM_GPIO-1:0] r_out;
  logic [NUM_GPIO-1:0] r_inten;
  logic [NUM_GPIO-1:0] r_type0;
  logic [NUM_GPIO-1:0] r_type1;
  logic [NUM_GPIO-1:0] r_status;
  logic [NUM_GPIO-1:0] r_filten;
  logic [15:0]         r_pre;
  logic [FILT_W-1:0]   r_thr;
  logic [31:0]         r_fun0;
  logic [31:0]         r_fun1;

  // Input path and filter state
  logic [NUM_GPIO-1:0] r_sync0;
  logic [NUM_GPIO-1:0] r_sync1;
  logic [NUM_GPIO-1:0] r_f;
  logic [NUM_GPIO-1:0] r_fd;
  logic [15:0]         r_presc;
  logic [FILT_W-1:0]   r_cnt [NUM_GPIO];

  // Decode and helpers
  logic [3:0]          w_off;
  logic                w_wr;
  logic                w_valid;
  logic [NUM_GPIO-1:0] w_wdata;
  logic [NUM_GPIO-1:0] w_w1c;
  logic [NUM_GPIO-1:0] w_cond;
  logic [63:0]         w_fun_mask;
  logic [63:0]         w_fun_all;
  logic                w_cfg_wr;
  logic                w_tick;
  logic [FILT_W-1:0]   w_thr_eff;
  logic [NUM_GPIO-1:0] w_cnt_hit;
  logic                w_unused_ok;

  assign w_off       = PADDR[5:2];
  assign w_wr        = PSEL & PENABLE & PWRITE;
  assign w_wdata     = PWDATA[NUM_GPIO-1:0];
  assign w_cfg_wr    = w_wr && (w_off == OFF_FILTCFG);
  assign w_w1c       = (w_wr && (w_off == OFF_INTSTATUS)) ? w_wdata : '0;
  assign w_tick      = (r_presc == r_pre);
  assign w_thr_eff   = (r_thr == '0) ? FILT_W'(1) : r_thr;
  assign w_unused_ok = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

  assign PREADY    = 1'b1;
  assign gpio_out  = r_out;
  assign gpio_dir  = r_dir;
  assign w_fun_all = {r_fun1, r_fun0};
  assign gpio_mux  = w_fun_all[2*NUM_GPIO-1:0];
  assign interrupt = |(r_status & r_inten);

  // Per-pin interrupt condition from the filtered value and its delayed copy
  assign w_cond = (~r_type1 & ~r_type0 &  r_f)
                | (~r_type1 &  r_type0 & ~r_f)
                | ( r_type1 & ~r_type0 &  r_f & ~r_fd)
                | ( r_type1 &  r_type0 & ~r_f &  r_fd);

  // Mask of implemented pad-function bits (2 per existing pin)
  always_comb begin
    w_fun_mask = '0;
    for (int unsigned i = 0; i < NUM_GPIO; i++) begin
      w_fun_mask[2*i +: 2] = 2'b11;
    end
  end

  // Per-pin: does the next tick bring the mismatch counter up to threshold
  always_comb begin
    w_cnt_hit = '0;
    for (int unsigned i = 0; i < NUM_GPIO; i++) begin
      w_cnt_hit[i] = (({1'b0, r_cnt[i]} + (FILT_W+1)'(1)) >= {1'b0, w_thr_eff});
    end
  end

  // Combinational read mux and undefined-offset detection
  always_comb begin
    PRDATA  = '0;
    w_valid = 1'b1;
    case (w_off)
      OFF_PADDIR:    PRDATA = 32'(r_dir);
      OFF_PADIN:     PRDATA = 32'(r_f);
      OFF_PADOUT:    PRDATA = 32'(r_out);
      OFF_PADOUTSET: PRDATA = '0;
      OFF_PADOUTCLR: PRDATA = '0;
      OFF_INTEN:     PRDATA = 32'(r_inten);
      OFF_INTTYPE0:  PRDATA = 32'(r_type0);
      OFF_INTTYPE1:  PRDATA = 32'(r_type1);
      OFF_INTSTATUS: PRDATA = 32'(r_status);
      OFF_FILTEN:    PRDATA = 32'(r_filten);
      OFF_FILTCFG:   PRDATA = 32'({r_thr, r_pre});
      OFF_PADFUN0:   PRDATA = r_fun0;
      OFF_PADFUN1:   PRDATA = r_fun1;
      default:       w_valid = 1'b0;
    endcase
  end

  assign PSLVERR = PSEL & PENABLE & ~w_valid;

  // APB register writes, including atomic set/clear on PADOUT
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dir    <= '0;
      r_out    <= '0;
      r_inten  <= '0;
      r_type0  <= '0;
      r_type1  <= '0;
      r_filten <= '0;
      r_pre    <= '0;
      r_thr    <= '0;
      r_fun0   <= '0;
      r_fun1   <= '0;
    end else if (w_wr) begin
      case (w_off)
        OFF_PADDIR:    r_dir    <= w_wdata;
        OFF_PADOUT:    r_out    <= w_wdata;
        OFF_PADOUTSET: r_out    <= r_out | w_wdata;
        OFF_PADOUTCLR: r_out    <= r_out & ~w_wdata;
        OFF_INTEN:     r_inten  <= w_wdata;
        OFF_INTTYPE0:  r_type0  <= w_wdata;
        OFF_INTTYPE1:  r_type1  <= w_wdata;
        OFF_FILTEN:    r_filten <= w_wdata;
        OFF_FILTCFG: begin
          r_pre <= PWDATA[15:0];
          r_thr <= PWDATA[16 +: FILT_W];
        end
        OFF_PADFUN0:   r_fun0   <= PWDATA & w_fun_mask[31:0];
        OFF_PADFUN1:   r_fun1   <= PWDATA & w_fun_mask[63:32];
        default: ;
      endcase
    end
  end

  // Sticky interrupt status: W1C is applied first so a same-cycle set wins
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_w1c) | w_cond;
    end
  end

  // Shared filter prescaler: counts 0..PRE, ticks at PRE; restarts on FILTCFG write
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_presc <= '0;
    end else if (w_cfg_wr || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Two-stage synchroniser, per-pin glitch filter and delayed filtered value
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
      r_f     <= '0;
      r_fd    <= '0;
      for (int unsigned i = 0; i < NUM_GPIO; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync0 <= gpio_in;
      r_sync1 <= r_sync0;
      r_fd    <= r_f;
      for (int unsigned i = 0; i < NUM_GPIO; i++) begin
        if (!r_filten[i]) begin
          r_f[i]   <= r_sync1[i];
          r_cnt[i] <= '0;
        end else if (w_cfg_wr || (r_sync1[i] == r_f[i])) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (w_cnt_hit[i]) begin
            r_f[i]   <= r_sync1[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + FILT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_gpio_ng.sv
// Directed self-checking bench for apb_gpio_ng.
module tb_apb_gpio_ng;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_dir;
  logic [63:0] gpio_mux;
  logic        interrupt;

  int checks   = 0;
  int failures = 0;

  apb_gpio_ng #(.APB_ADDR_WIDTH(12), .NUM_GPIO(32), .FILT_W(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_dir(gpio_dir), .gpio_mux(gpio_mux),
    .interrupt(interrupt)
  );

  always #5 HCLK = ~HCLK;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    gpio_in = '0;
    HRESET = 1'b1;
    wait_edges(2);
    HRESET = 1'b0;
  endtask

  // Commit edge is the third rising edge after the call; returns 1 ns after it
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #2;
    d = PRDATA; err = PSLVERR;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    logic [11:0] a;
    do_reset();
    checks++;
    if (gpio_out !== 32'h0 || gpio_dir !== 32'h0) begin
      failures++; $display("FAIL reset_pads out=%h dir=%h exp 0", gpio_out, gpio_dir);
    end
    checks++;
    if (gpio_mux !== 64'h0) begin
      failures++; $display("FAIL reset_mux got=%h exp=0", gpio_mux);
    end
    checks++;
    if (interrupt !== 1'b0) begin
      failures++; $display("FAIL reset_irq got=%b exp=0", interrupt);
    end
    checks++;
    if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      failures++; $display("FAIL reset_apb pready=%b pslverr=%b exp 1/0", PREADY, PSLVERR);
    end
    for (int i = 0; i <= 13; i++) begin
      a = 12'(i * 4);
      apb_read(a, d, e);
      checks++;
      if (d !== 32'h0) begin
        failures++; $display("FAIL reset_read[%h] got=%h exp=0", a, d);
      end
      checks++;
      if (e !== (i == 13)) begin
        failures++; $display("FAIL reset_slverr[%h] got=%b exp=%b", a, e, (i == 13));
      end
    end
  endtask

  task automatic test_outset();
    logic [31:0] d;
    logic        e;
    do_reset();
    apb_write(12'h008, 32'h0000_00F0);
    apb_write(12'h00C, 32'h0000_000F);
    checks++;
    if (gpio_out !== 32'h0000_00FF) begin
      failures++; $display("FAIL outset got=%h exp=000000ff", gpio_out);
    end
    apb_write(12'h010, 32'h0000_0081);
    checks++;
    if (gpio_out !== 32'h0000_007E) begin
      failures++; $display("FAIL outclr got=%h exp=0000007e", gpio_out);
    end
    apb_read(12'h008, d, e);
    checks++;
    if (d !== 32'h0000_007E) begin
      failures++; $display("FAIL padout_read got=%h exp=0000007e", d);
    end
    apb_read(12'h00C, d, e);
    checks++;
    if (d !== 32'h0) begin
      failures++; $display("FAIL outset_read got=%h exp=0", d);
    end
    apb_write(12'h000, 32'hA5A5_3C3C);
    checks++;
    if (gpio_dir !== 32'hA5A5_3C3C) begin
      failures++; $display("FAIL paddir got=%h exp=a5a53c3c", gpio_dir);
    end
    apb_write(12'h02C, 32'h1234_5678);
    apb_write(12'h030, 32'h9ABC_DEF0);
    checks++;
    if (gpio_mux !== 64'h9ABC_DEF0_1234_5678) begin
      failures++; $display("FAIL padfun got=%h exp=9abcdef012345678", gpio_mux);
    end
    apb_write(12'h028, 32'hFFFF_FFFF);
    apb_read(12'h028, d, e);
    checks++;
    if (d !== 32'h000F_FFFF) begin
      failures++; $display("FAIL filtcfg_read got=%h exp=000fffff", d);
    end
    // Write to an undefined offset must not disturb existing state
    apb_write(12'h034, 32'hFFFF_FFFF);
    checks++;
    if (gpio_out !== 32'h0000_007E || gpio_dir !== 32'hA5A5_3C3C) begin
      failures++; $display("FAIL undef_write out=%h dir=%h exp 7e/a5a53c3c", gpio_out, gpio_dir);
    end
  endtask

  task automatic test_edge_irq();
    do_reset();
    apb_write(12'h01C, 32'h0000_0008);   // pin 3 rising edge
    apb_write(12'h014, 32'h0000_0008);
    PADDR = 12'h020;
    gpio_in[3] = 1'b1;                   // stable before edge N
    wait_edges(3);                       // after N+2
    checks++;
    if (interrupt !== 1'b0) begin
      failures++; $display("FAIL edge_early got=%b exp=0", interrupt);
    end
    wait_edges(1);                       // after N+3
    checks++;
    if (interrupt !== 1'b1 || PRDATA !== 32'h8) begin
      failures++; $display("FAIL edge_set irq=%b status=%h exp 1/8", interrupt, PRDATA);
    end
    apb_write(12'h020, 32'h0000_0008);
    PADDR = 12'h020; #1;
    checks++;
    if (interrupt !== 1'b0 || PRDATA !== 32'h0) begin
      failures++; $display("FAIL edge_w1c irq=%b status=%h exp 0/0", interrupt, PRDATA);
    end
    gpio_in[3] = 1'b0;
    wait_edges(4);
    gpio_in[3] = 1'b1;                   // stable before edge N; set lands at N+3
    @(posedge HCLK);                     // edge N
    apb_write(12'h020, 32'h0000_0008);   // commits at N+3
    PADDR = 12'h020; #1;
    checks++;
    if (interrupt !== 1'b1 || PRDATA !== 32'h8) begin
      failures++; $display("FAIL set_wins irq=%b status=%h exp 1/8", interrupt, PRDATA);
    end
    apb_write(12'h020, 32'h0000_0008);
    checks++;
    if (interrupt !== 1'b0) begin
      failures++; $display("FAIL edge_final got=%b exp=0", interrupt);
    end
  endtask

  task automatic test_level();
    do_reset();
    apb_write(12'h018, 32'h0000_0002);   // pin 1 level low, others level high
    apb_write(12'h014, 32'h0000_0001);
    PADDR = 12'h020; #1;
    checks++;
    if (PRDATA !== 32'h2 || interrupt !== 1'b0) begin
      failures++; $display("FAIL level_noen status=%h irq=%b exp 2/0", PRDATA, interrupt);
    end
    gpio_in[0] = 1'b1;
    wait_edges(4);
    checks++;
    if (PRDATA !== 32'h3 || interrupt !== 1'b1) begin
      failures++; $display("FAIL level_set status=%h irq=%b exp 3/1", PRDATA, interrupt);
    end
    apb_write(12'h020, 32'h0000_0001);
    PADDR = 12'h020; #1;
    checks++;
    if (PRDATA !== 32'h3 || interrupt !== 1'b1) begin
      failures++; $display("FAIL level_hold status=%h irq=%b exp 3/1", PRDATA, interrupt);
    end
    gpio_in[0] = 1'b0;
    wait_edges(4);
    checks++;
    if (PRDATA !== 32'h3) begin
      failures++; $display("FAIL level_sticky status=%h exp=3", PRDATA);
    end
    apb_write(12'h020, 32'h0000_0001);
    PADDR = 12'h020; #1;
    checks++;
    if (PRDATA !== 32'h2 || interrupt !== 1'b0) begin
      failures++; $display("FAIL level_clear status=%h irq=%b exp 2/0", PRDATA, interrupt);
    end
  endtask

  task automatic test_filter();
    logic seen;
    do_reset();
    apb_write(12'h01C, 32'h0000_0020);   // pin 5 rising edge
    apb_write(12'h024, 32'h0000_0020);
    apb_write(12'h028, 32'h0002_0003);   // THR=2, PRE=3; commit edge W, ticks at W+4k
    PADDR = 12'h004;
    gpio_in[5] = 1'b1;                   // high for edges W+1..W+5
    wait_edges(5);
    gpio_in[5] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wait_edges(1);
      if (PRDATA[5] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || PRDATA[5] !== 1'b0) begin
      failures++; $display("FAIL filt_reject seen=%b padin5=%b exp 0/0", seen, PRDATA[5]);
    end
    PADDR = 12'h020; #1;
    checks++;
    if (PRDATA !== 32'h0 || interrupt !== 1'b0) begin
      failures++; $display("FAIL filt_noirq status=%h irq=%b exp 0/0", PRDATA, interrupt);
    end
    PADDR = 12'h004;
    gpio_in[5] = 1'b1;                   // from W+13; cnt=1 at W+16, f at W+20
    wait_edges(7);
    checks++;
    if (PRDATA[5] !== 1'b0) begin
      failures++; $display("FAIL filt_early padin5=%b exp=0", PRDATA[5]);
    end
    wait_edges(1);
    checks++;
    if (PRDATA[5] !== 1'b1) begin
      failures++; $display("FAIL filt_pass padin5=%b exp=1", PRDATA[5]);
    end
    wait_edges(1);
    PADDR = 12'h020; #1;
    checks++;
    if (PRDATA !== 32'h20) begin
      failures++; $display("FAIL filt_edge status=%h exp=20", PRDATA);
    end
    wait_edges(4);
    gpio_in[5] = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    gpio_in[0] = 1'b1;                   // level-high status on pin 0
    apb_write(12'h000, 32'h0000_00FF);
    apb_write(12'h008, 32'h0000_005A);
    apb_write(12'h02C, 32'h0000_0003);
    apb_write(12'h014, 32'h0000_0001);
    apb_write(12'h024, 32'h0000_0020);
    apb_write(12'h028, 32'h0002_0003);   // commit edge W
    gpio_in[5] = 1'b1;
    wait_edges(5);                       // after W+5: cnt[5]=1, f[5]=0
    PADDR = 12'h004; #1;
    checks++;
    if (PRDATA !== 32'h1 || interrupt !== 1'b1 || gpio_out !== 32'h5A) begin
      failures++; $display("FAIL mid_state padin=%h irq=%b out=%h exp 1/1/5a", PRDATA, interrupt, gpio_out);
    end
    HRESET = 1'b1;
    wait_edges(1);                       // reset edge R
    checks++;
    if (gpio_out !== 32'h0 || gpio_dir !== 32'h0 || gpio_mux !== 64'h0 || interrupt !== 1'b0) begin
      failures++; $display("FAIL mid_reset out=%h dir=%h mux=%h irq=%b exp all 0", gpio_out, gpio_dir, gpio_mux, interrupt);
    end
    PADDR = 12'h020; #1;
    checks++;
    if (PRDATA !== 32'h0) begin
      failures++; $display("FAIL mid_reset_status got=%h exp=0", PRDATA);
    end
    HRESET = 1'b0;
    PADDR = 12'h004;
    wait_edges(2);                       // after R+2
    checks++;
    if (PRDATA !== 32'h0) begin
      failures++; $display("FAIL mid_restart_early padin=%h exp=0", PRDATA);
    end
    wait_edges(1);                       // after R+3, filter now disabled
    checks++;
    if (PRDATA !== 32'h21) begin
      failures++; $display("FAIL mid_restart padin=%h exp=21", PRDATA);
    end
  endtask

  initial begin
    test_reset();
    test_outset();
    test_edge_irq();
    test_level();
    test_filter();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_gpio_ng.md
# apb_gpio_ng

Parametrised next-generation APB GPIO controller for up to 32 pads. It provides per-pin direction, output, pad-mux function and interrupt configuration, and adds atomic output set/clear, sticky write-1-to-clear interrupt status and a per-pin programmable glitch filter. It sits on the peripheral APB bus as a 4 KB slave; its outputs drive the pad frame and its interrupt feeds the event/interrupt controller.

## Interface
- APB_ADDR_WIDTH, 12, APB address width.
- NUM_GPIO, 32, number of pins (1..32).
- FILT_W, 4, width of each per-pin filter counter and of the filter threshold field.
- HCLK  in  1  clock; all logic is on the rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- PADDR  in  APB_ADDR_WIDTH  APB address; only PADDR[5:2] is decoded.
- PWDATA  in  32  APB write data.
- PWRITE, PSEL, PENABLE  in  1  APB control.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied to 1; no wait states.
- PSLVERR  out  1  high during the access phase to an undefined offset.
- gpio_in  in  NUM_GPIO  asynchronous pad inputs.
- gpio_out  out  NUM_GPIO  pad output values.
- gpio_dir  out  NUM_GPIO  pad output enables (1 = output).
- gpio_mux  out  2*NUM_GPIO  pad function select, 2 bits per pin.
- interrupt  out  1  level interrupt, equal to |(INTSTATUS & INTEN).

## Operation
- Writes commit at an edge where PSEL & PENABLE & PWRITE. PRDATA is combinational on PADDR[5:2].
- Bits at or above NUM_GPIO: ignored on write, read as 0. Undefined offsets read 0 and have no write effect.
- Register map (offset, access):
  - 0x00 PADDIR (RW)
  - 0x04 PADIN (RO, filtered input)
  - 0x08 PADOUT (RW)
  - 0x0C PADOUTSET (WO): PADOUT |= PWDATA; reads 0
  - 0x10 PADOUTCLR (WO): PADOUT &= ~PWDATA; reads 0
  - 0x14 INTEN (RW)
  - 0x18 INTTYPE0 (RW)
  - 0x1C INTTYPE1 (RW)
  - 0x20 INTSTATUS (RW1C)
  - 0x24 FILTEN (RW)
  - 0x28 FILTCFG (RW): [15:0] prescaler PRE, [16+:FILT_W] threshold THR
  - 0x2C PADFUN0 (RW): pins 0..15
  - 0x30 PADFUN1 (RW): pins 16..31
- Input path per pin: sync0 <- gpio_in, sync1 <- sync0, then filter register f; f_d <- f. PADIN = f.
- Filter:
  - Shared prescaler counter runs 0..PRE and issues a one-cycle tick when it equals PRE, then wraps to 0.
  - FILTEN[i]=0: f[i] <- sync1[i] every cycle and cnt[i] <- 0.
  - FILTEN[i]=1:
    - If sync1[i]==f[i], cnt[i] <- 0.
    - Otherwise cnt[i] increments on each tick. When the increment reaches THR, f[i] <- sync1[i] and cnt[i] <- 0.
    - THR=0 is treated as 1.
  - Writing FILTCFG clears the prescaler and all cnt.
- Interrupt type per pin, {INTTYPE1, INTTYPE0}:
  - 00: level high (f)
  - 01: level low (~f)
  - 10: rising edge (f & ~f_d)
  - 11: falling edge (~f & f_d)
- INTSTATUS[i] sets when its condition is true, regardless of INTEN. Writing 1 to a bit clears it. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Level types re-set the status every cycle while the condition holds, so a clear does not stick while the condition is active.
- interrupt is combinational from registered INTSTATUS & INTEN.

## Timing
- Reset values:
  - All registers, sync/filter state, prescaler and counters are 0.
  - gpio_out, gpio_dir, gpio_mux and interrupt are 0. PSLVERR is 0.
- Unfiltered path: gpio_in is stable from before edge N. PADIN reflects it after edge N+2. An edge-type INTSTATUS bit and interrupt go high after edge N+3.
- Filtered path: add (THR×(PRE+1)) cycles maximum, (THR−1)×(PRE+1)+1 minimum, after sync1 changes.
- A pulse shorter than one tick period is always rejected when THR≥2.
- A register write is visible on outputs from the edge after the access phase. A W1C write drops interrupt in the same edge if no new set occurs.
- HRESET asserted mid-operation clears everything at the next edge, including pending status and partial filter counts.

## Test plan
- Reset, then read all offsets -> all 0 except PADIN=0. A read at 0x34 gives PSLVERR=1 and PRDATA=0.
- Write PADOUT=0xF0, PADOUTSET=0x0F, then PADOUTCLR=0x81 -> gpio_out=0xFF, then 0x7E.
- INTTYPE=10 on pin 3, INTEN[3]=1, then raise gpio_in[3] at edge N:
  - interrupt rises after edge N+3 and INTSTATUS=0x8.
  - W1C of 0x8 clears both.
  - A second rise in the same cycle as a W1C leaves the bit set.
- Level-high on pin 0 held high -> a W1C does not clear the status. Dropping pin 0 and then writing W1C clears it.
- FILTEN[5]=1, PRE=3, THR=2: a 5-cycle high pulse leaves PADIN[5]=0 with no edge interrupt. A level held 12 cycles sets PADIN[5]=1 by 2+8 cycles.
- Assert HRESET mid-filter count and with interrupt pending -> all outputs are 0 at the next edge and the filter restarts from 0.
